// File: rtl/riscv_pkg.sv
// Shared RV32I opcode/field constants and the decoded-instruction record
// passed from the class lookup to the predecoder buffers.
package riscv_pkg;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_LW    = 7'b0000011;
  localparam logic [6:0] OPC_ADDI  = 7'b0010011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_SB    = 7'b1100011;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_UJ    = 7'b1101111;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic       r_type;
    logic       i_type_lw;
    logic       i_type_addi;
    logic       i_type_jalr;
    logic       s_type;
    logic       sb_type;
    logic       u_type_auipc;
    logic       u_type_lui;
    logic       uj_type;
    logic       illegal;
    logic [2:0] func_3;
    logic       func_7_bit_6;
  } decoded_instr_t;

endpackage

// File: rtl/instruction_type_predecoder_if.sv
// Upstream/downstream handshake and decoded-output bundle of the predecoder.
// The slave modport is the predecoder side; master is the driver/consumer side.
interface instruction_type_predecoder_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_instruction;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic             r_type;
  logic             i_type_lw;
  logic             i_type_addi;
  logic             i_type_jalr;
  logic             s_type;
  logic             sb_type;
  logic             u_type_auipc;
  logic             u_type_lui;
  logic             uj_type;
  logic [2:0]       func_3;
  logic             func_7_bit_6;
  logic             illegal;
  logic [CNT_W-1:0] illegal_count;

  modport master (
    output flush, in_valid, in_instruction, in_pc, out_ready,
    input  in_ready, out_valid, out_pc,
    input  r_type, i_type_lw, i_type_addi, i_type_jalr, s_type, sb_type,
    input  u_type_auipc, u_type_lui, uj_type,
    input  func_3, func_7_bit_6, illegal, illegal_count
  );

  modport slave (
    input  flush, in_valid, in_instruction, in_pc, out_ready,
    output in_ready, out_valid, out_pc,
    output r_type, i_type_lw, i_type_addi, i_type_jalr, s_type, sb_type,
    output u_type_auipc, u_type_lui, uj_type,
    output func_3, func_7_bit_6, illegal, illegal_count
  );
endinterface

// File: rtl/instruction_class_lookup.sv
// Combinational opcode/funct classifier: raw instruction word -> one-hot
// class plus illegal flag. Unsupported encodings leave every class bit clear.
module instruction_class_lookup
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instruction,
  output decoded_instr_t  decoded
);

  logic [6:0] opcode;
  logic [2:0] func_3;
  logic [6:0] func_7;
  logic       unused_fields;

  assign opcode        = instruction[6:0];
  assign func_3        = instruction[14:12];
  assign func_7        = instruction[31:25];
  assign unused_fields = ^{instruction[24:15], instruction[11:7]};

  always_comb begin
    decoded              = '0;
    decoded.func_3       = func_3;
    decoded.func_7_bit_6 = instruction[30];
    case (opcode)
      OPC_R:     decoded.r_type       = (func_7 == F7_BASE) || (func_7 == F7_ALT);
      OPC_LW:    decoded.i_type_lw    = (func_3 == F3_LW);
      OPC_ADDI:  decoded.i_type_addi  = 1'b1;
      OPC_JALR:  decoded.i_type_jalr  = (func_3 == F3_JALR);
      OPC_S:     decoded.s_type       = (func_3 == F3_SW);
      OPC_SB:    decoded.sb_type      = 1'b1;
      OPC_AUIPC: decoded.u_type_auipc = 1'b1;
      OPC_LUI:   decoded.u_type_lui   = 1'b1;
      OPC_UJ:    decoded.uj_type      = 1'b1;
      default:   ;
    endcase
    // Illegal is exactly "no class matched", which keeps the output one-hot-or-none.
    decoded.illegal = ~|{decoded.r_type, decoded.i_type_lw, decoded.i_type_addi,
                         decoded.i_type_jalr, decoded.s_type, decoded.sb_type,
                         decoded.u_type_auipc, decoded.u_type_lui, decoded.uj_type};
  end

endmodule

// File: rtl/instruction_type_predecoder.sv
// Predecode stage: classify at accept, hold results in a main/skid pair so
// in_ready is a flop, and count consumed illegal words with saturation.
module instruction_type_predecoder
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input logic                          clk,
  input logic                          rst,
  instruction_type_predecoder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  decoded_instr_t   in_dec;
  decoded_instr_t   main_dec;
  decoded_instr_t   skid_dec;
  logic [XLEN-1:0]  main_pc;
  logic [XLEN-1:0]  skid_pc;
  logic             main_valid;
  logic             skid_valid;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             consume;
  logic             main_free;

  instruction_class_lookup #(.XLEN(XLEN)) u_lookup (
    .instruction (bus.in_instruction),
    .decoded     (in_dec)
  );

  assign accept    = bus.in_valid & ~skid_valid;
  assign consume   = main_valid & bus.out_ready;
  assign main_free = ~main_valid | consume;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_dec   <= '0;
      skid_dec   <= '0;
      main_pc    <= '0;
      skid_pc    <= '0;
      cnt        <= '0;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      // Skid is only full when in_ready was low, so it never competes with accept.
      if (consume && skid_valid) begin
        main_dec   <= skid_dec;
        main_pc    <= skid_pc;
        skid_valid <= 1'b0;
      end else if (accept && main_free) begin
        main_dec   <= in_dec;
        main_pc    <= bus.in_pc;
        main_valid <= 1'b1;
      end else if (accept) begin
        skid_dec   <= in_dec;
        skid_pc    <= bus.in_pc;
        skid_valid <= 1'b1;
      end else if (consume) begin
        main_valid <= 1'b0;
      end

      if (consume && main_dec.illegal && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready      = ~skid_valid;
  assign bus.out_valid     = main_valid;
  assign bus.out_pc        = main_pc;
  assign bus.r_type        = main_dec.r_type;
  assign bus.i_type_lw     = main_dec.i_type_lw;
  assign bus.i_type_addi   = main_dec.i_type_addi;
  assign bus.i_type_jalr   = main_dec.i_type_jalr;
  assign bus.s_type        = main_dec.s_type;
  assign bus.sb_type       = main_dec.sb_type;
  assign bus.u_type_auipc  = main_dec.u_type_auipc;
  assign bus.u_type_lui    = main_dec.u_type_lui;
  assign bus.uj_type       = main_dec.uj_type;
  assign bus.func_3        = main_dec.func_3;
  assign bus.func_7_bit_6  = main_dec.func_7_bit_6;
  assign bus.illegal       = main_dec.illegal;
  assign bus.illegal_count = cnt;

endmodule
